commit_window_ctrl: RTL and testbench

//  N-wide in-order retirement controller between scoreboard and architectural state (regfile, LSU, CSR, fences).

---
 rtl/commit_window_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_commit_window_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/commit_window_ctrl.sv
// In-order retirement controller: acks the longest committable prefix of the
// commit window and sequences fences/AMOs through a small registered FSM.
module commit_window_ctrl #(
   parameter int unsigned NR_COMMIT_PORTS  = 4,
   parameter int unsigned STORES_PER_CYCLE = 1,
   parameter int unsigned XLEN             = 64,
   parameter logic [63:0] INSTRET_INIT     = '0
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              halt_i,
   input  logic                              single_step_i,
   input  logic [NR_COMMIT_PORTS-1:0]        commit_valid_i,
   input  logic [NR_COMMIT_PORTS-1:0]        commit_ex_i,
   input  logic [NR_COMMIT_PORTS*3-1:0]      commit_kind_i,
   input  logic [NR_COMMIT_PORTS-1:0]        commit_fpr_i,
   input  logic [NR_COMMIT_PORTS*5-1:0]      commit_rd_i,
   input  logic [NR_COMMIT_PORTS*XLEN-1:0]   commit_result_i,
   input  logic                              lsu_ready_i,
   input  logic                              no_st_pending_i,
   input  logic                              csr_ex_i,
   input  logic [XLEN-1:0]                   csr_rdata_i,
   input  logic                              amo_ack_i,
   input  logic [XLEN-1:0]                   amo_result_i,
   output logic [NR_COMMIT_PORTS-1:0]        commit_ack_o,
   output logic [NR_COMMIT_PORTS-1:0]        we_gpr_o,
   output logic [NR_COMMIT_PORTS-1:0]        we_fpr_o,
   output logic [NR_COMMIT_PORTS*5-1:0]      waddr_o,
   output logic [NR_COMMIT_PORTS*XLEN-1:0]   wdata_o,
   output logic [NR_COMMIT_PORTS-1:0]        commit_lsu_o,
   output logic                              commit_csr_o,
   output logic                              fence_o,
   output logic                              fence_i_o,
   output logic                              sfence_vma_o,
   output logic                              flush_o,
   output logic                              amo_valid_o,
   output logic                              exception_o,
   output logic                              busy_o,
   output logic [$clog2(NR_COMMIT_PORTS+1)-1:0] retire_cnt_o,
   output logic [63:0]                       instret_o
);

   localparam int unsigned N  = NR_COMMIT_PORTS;
   localparam int unsigned CW = $clog2(N + 1);

   typedef enum logic [2:0] {
      K_ALU     = 3'd0,
      K_STORE   = 3'd1,
      K_CSR     = 3'd2,
      K_FENCE   = 3'd3,
      K_FENCE_I = 3'd4,
      K_SFENCE  = 3'd5,
      K_AMO     = 3'd6,
      K_FPU     = 3'd7
   } kind_e;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DRAIN    = 2'd1,
      AMO_WAIT = 2'd2
   } state_e;

   state_e          state_q;
   state_e          state_d;
   logic [63:0]     instret_q;
   kind_e           kind [N];
   kind_e           k0;
   logic [N-1:0]    ack;
   logic            amo_v;
   logic            exc;
   logic [CW-1:0]   cnt;

   always_comb begin
      for (int i = 0; i < int'(N); i++) begin
         kind[i] = kind_e'(commit_kind_i[i*3 +: 3]);
      end
   end

   assign k0 = kind[0];

   always_comb begin : p_window
      logic        open;
      int unsigned st_cnt;
      ack     = '0;
      amo_v   = 1'b0;
      exc     = 1'b0;
      state_d = state_q;
      open    = 1'b1;
      st_cnt  = 0;
      if (!rst_i && !halt_i) begin
         exc = commit_valid_i[0] &
               (commit_ex_i[0] | ((k0 == K_CSR) & csr_ex_i));
         unique case (state_q)
            IDLE: begin
               for (int i = 0; i < int'(N); i++) begin
                  if (open) begin
                     if (!commit_valid_i[i] || commit_ex_i[i] ||
                         (i != 0 && single_step_i)) begin
                        open = 1'b0;
                     end else begin
                        unique case (kind[i])
                           K_ALU, K_FPU: ack[i] = 1'b1;
                           K_STORE: begin
                              if (lsu_ready_i &&
                                  st_cnt < STORES_PER_CYCLE) begin
                                 ack[i] = 1'b1;
                                 st_cnt = st_cnt + 1;
                              end else begin
                                 open = 1'b0;
                              end
                           end
                           default: begin
                              // serialising kinds close the window
                              open = 1'b0;
                              if (i == 0) begin
                                 unique case (k0)
                                    K_CSR: ack[0] = !csr_ex_i;
                                    K_FENCE, K_FENCE_I, K_SFENCE: begin
                                       if (no_st_pending_i) ack[0] = 1'b1;
                                       else state_d = DRAIN;
                                    end
                                    K_AMO: begin
                                       amo_v = 1'b1;
                                       if (amo_ack_i) ack[0] = 1'b1;
                                       else state_d = AMO_WAIT;
                                    end
                                    default: ;
                                 endcase
                              end
                           end
                        endcase
                     end
                  end
               end
            end
            DRAIN: begin
               if (!commit_valid_i[0]) begin
                  state_d = IDLE;
               end else if (no_st_pending_i) begin
                  ack[0]  = 1'b1;
                  state_d = IDLE;
               end
            end
            AMO_WAIT: begin
               amo_v = commit_valid_i[0];
               if (!commit_valid_i[0]) begin
                  state_d = IDLE;
               end else if (amo_ack_i) begin
                  ack[0]  = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      cnt = '0;
      for (int i = 0; i < int'(N); i++) begin
         cnt = cnt + CW'(ack[i]);
      end
   end

   always_comb begin
      waddr_o      = '0;
      wdata_o      = '0;
      commit_lsu_o = '0;
      if (!rst_i) begin
         waddr_o = commit_rd_i;
         for (int i = 0; i < int'(N); i++) begin
            wdata_o[i*XLEN +: XLEN] = commit_result_i[i*XLEN +: XLEN];
            commit_lsu_o[i]         = ack[i] & (kind[i] == K_STORE);
         end
         if (k0 == K_CSR) wdata_o[XLEN-1:0] = csr_rdata_i;
         if (k0 == K_AMO) wdata_o[XLEN-1:0] = amo_result_i;
      end
   end

   assign commit_ack_o = ack;
   assign we_gpr_o     = ack & ~commit_fpr_i;
   assign we_fpr_o     = ack & commit_fpr_i;
   assign commit_csr_o = ack[0] & (k0 == K_CSR);
   assign fence_o      = ack[0] & (k0 == K_FENCE);
   assign fence_i_o    = ack[0] & (k0 == K_FENCE_I);
   assign sfence_vma_o = ack[0] & (k0 == K_SFENCE);
   assign flush_o      = ack[0] & (k0 == K_AMO);
   assign amo_valid_o  = amo_v;
   assign exception_o  = exc;
   assign busy_o       = !rst_i && (state_q != IDLE);
   assign retire_cnt_o = cnt;
   assign instret_o    = instret_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         instret_q <= INSTRET_INIT;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_q + 64'(cnt);
      end
   end

endmodule

// File: tb/tb_commit_window_ctrl.sv
// Directed bench for commit_window_ctrl; a second instance reset near
// 2^64 exercises instret wrap.
module tb_commit_window_ctrl;

   localparam int N  = 4;
   localparam int XL = 64;

   logic            clk = 1'b0;
   logic            rst, halt, step;
   logic [N-1:0]    valid, ex, fpr;
   logic [N*3-1:0]  kind;
   logic [N*5-1:0]  rd;
   logic [N*XL-1:0] res;
   logic            lsu_rdy, no_st, csr_ex, amo_ack;
   logic [XL-1:0]   csr_rd, amo_res;

   logic [N-1:0]    ack, we_gpr, we_fpr, lsu;
   logic [N*5-1:0]  waddr;
   logic [N*XL-1:0] wdata;
   logic            csr_c, fence, fence_i, sfence, flush, amo_v, exc, busy;
   logic [2:0]      rcnt;
   logic [63:0]     instret;

   logic [N-1:0]    w_ack, w_we_gpr, w_we_fpr, w_lsu;
   logic [N*5-1:0]  w_waddr;
   logic [N*XL-1:0] w_wdata;
   logic            w_csr_c, w_fence, w_fence_i, w_sfence, w_flush;
   logic            w_amo_v, w_exc, w_busy;
   logic [2:0]      w_rcnt;
   logic [63:0]     w_instret;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   commit_window_ctrl #(.NR_COMMIT_PORTS(N), .STORES_PER_CYCLE(1),
                        .XLEN(XL)) dut (
      .clk_i(clk), .rst_i(rst), .halt_i(halt), .single_step_i(step),
      .commit_valid_i(valid), .commit_ex_i(ex), .commit_kind_i(kind),
      .commit_fpr_i(fpr), .commit_rd_i(rd), .commit_result_i(res),
      .lsu_ready_i(lsu_rdy), .no_st_pending_i(no_st), .csr_ex_i(csr_ex),
      .csr_rdata_i(csr_rd), .amo_ack_i(amo_ack), .amo_result_i(amo_res),
      .commit_ack_o(ack), .we_gpr_o(we_gpr), .we_fpr_o(we_fpr),
      .waddr_o(waddr), .wdata_o(wdata), .commit_lsu_o(lsu),
      .commit_csr_o(csr_c), .fence_o(fence), .fence_i_o(fence_i),
      .sfence_vma_o(sfence), .flush_o(flush), .amo_valid_o(amo_v),
      .exception_o(exc), .busy_o(busy), .retire_cnt_o(rcnt),
      .instret_o(instret)
   );

   commit_window_ctrl #(.NR_COMMIT_PORTS(N), .STORES_PER_CYCLE(1),
                        .XLEN(XL),
                        .INSTRET_INIT(64'hFFFF_FFFF_FFFF_FFFD)) u_wrap (
      .clk_i(clk), .rst_i(rst), .halt_i(halt), .single_step_i(step),
      .commit_valid_i(valid), .commit_ex_i(ex), .commit_kind_i(kind),
      .commit_fpr_i(fpr), .commit_rd_i(rd), .commit_result_i(res),
      .lsu_ready_i(lsu_rdy), .no_st_pending_i(no_st), .csr_ex_i(csr_ex),
      .csr_rdata_i(csr_rd), .amo_ack_i(amo_ack), .amo_result_i(amo_res),
      .commit_ack_o(w_ack), .we_gpr_o(w_we_gpr), .we_fpr_o(w_we_fpr),
      .waddr_o(w_waddr), .wdata_o(w_wdata), .commit_lsu_o(w_lsu),
      .commit_csr_o(w_csr_c), .fence_o(w_fence), .fence_i_o(w_fence_i),
      .sfence_vma_o(w_sfence), .flush_o(w_flush), .amo_valid_o(w_amo_v),
      .exception_o(w_exc), .busy_o(w_busy), .retire_cnt_o(w_rcnt),
      .instret_o(w_instret)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rst     = 1'b0;
      halt    = 1'b0;
      step    = 1'b0;
      valid   = '0;
      ex      = '0;
      fpr     = '0;
      kind    = '0;
      lsu_rdy = 1'b1;
      no_st   = 1'b1;
      csr_ex  = 1'b0;
      amo_ack = 1'b0;
      csr_rd  = 64'hC5C5;
      amo_res = '0;
      for (int i = 0; i < N; i++) begin
         rd[i*5 +: 5]   = 5'(i + 1);
         res[i*XL +: XL] = 64'h100 + 64'(i);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic ent(input int i, input logic [2:0] k);
      valid[i]       = 1'b1;
      kind[i*3 +: 3] = k;
   endtask

   task automatic alu4();
      for (int i = 0; i < N; i++) ent(i, 3'd0);
   endtask

   initial begin
      idle(); rst = 1'b1; alu4(); #1;
      chk("rst_ack", ack, 0);
      chk("rst_cnt", rcnt, 0);
      cyc(); rst = 1'b1; alu4(); #1;
      chk("rst_instret", instret, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ack2", ack, 0);

      cyc(); alu4(); fpr[1] = 1'b1; #1;
      chk("alu4_ack", ack, 4'b1111);
      chk("alu4_cnt", rcnt, 4);
      chk("alu4_gpr", we_gpr, 4'b1101);
      chk("alu4_fpr", we_fpr, 4'b0010);
      chk("alu4_wdata2", wdata[2*XL +: XL], 64'h102);
      chk("alu4_waddr3", waddr[3*5 +: 5], 5'd4);
      cyc(); #1;
      chk("instret_4", instret, 4);
      chk("instret_wrap", w_instret, 1);
      chk("idle_ack", ack, 0);

      cyc(); ent(0, 3'd1); ent(1, 3'd1); ent(2, 3'd0); ent(3, 3'd0); #1;
      chk("stst_ack", ack, 4'b0001);
      chk("stst_lsu", lsu, 4'b0001);
      cyc(); ent(0, 3'd0); ent(1, 3'd1); ent(2, 3'd1); ent(3, 3'd0); #1;
      chk("alst_ack", ack, 4'b0011);
      chk("alst_lsu", lsu, 4'b0010);
      cyc(); ent(0, 3'd1); ent(1, 3'd0); lsu_rdy = 1'b0; #1;
      chk("st_nordy_ack", ack, 0);

      cyc(); ent(0, 3'd3); ent(1, 3'd0); no_st = 1'b0; #1;
      chk("fen1_ack", ack, 0);
      chk("fen1_busy", busy, 0);
      chk("fen1_pulse", fence, 0);
      for (int c = 2; c <= 3; c++) begin
         cyc(); ent(0, 3'd3); ent(1, 3'd0); no_st = 1'b0; #1;
         chk("fen_wait_busy", busy, 1);
         chk("fen_wait_ack", ack, 0);
         chk("fen_wait_pulse", fence, 0);
      end
      cyc(); ent(0, 3'd3); ent(1, 3'd0); #1;
      chk("fen4_ack", ack, 4'b0001);
      chk("fen4_pulse", fence, 1);
      chk("fen4_busy", busy, 1);
      cyc(); #1;
      chk("fen5_busy", busy, 0);
      chk("fen5_pulse", fence, 0);
      chk("instret_8", instret, 8);
      cyc(); ent(0, 3'd4); ent(1, 3'd0); #1;
      chk("fi_ack", ack, 4'b0001);
      chk("fi_pulse", fence_i, 1);
      chk("fi_fence", fence, 0);

      cyc(); ent(0, 3'd6); ent(1, 3'd0); #1;
      chk("amo1_valid", amo_v, 1);
      chk("amo1_ack", ack, 0);
      cyc(); ent(0, 3'd6); ent(1, 3'd0); #1;
      chk("amo2_busy", busy, 1);
      chk("amo2_valid", amo_v, 1);
      cyc(); ent(0, 3'd6); halt = 1'b1; amo_ack = 1'b1; amo_res = 64'hBAD; #1;
      chk("amo_halt_ack", ack, 0);
      chk("amo_halt_flush", flush, 0);
      cyc(); ent(0, 3'd6); #1;
      chk("amo4_busy", busy, 1);
      chk("amo4_valid", amo_v, 1);
      cyc(); ent(0, 3'd6); amo_ack = 1'b1; amo_res = 64'hDEAD; #1;
      chk("amo5_ack", ack, 4'b0001);
      chk("amo5_wdata", wdata[XL-1:0], 64'hDEAD);
      chk("amo5_gpr", we_gpr, 4'b0001);
      chk("amo5_flush", flush, 1);
      cyc(); #1;
      chk("amo6_busy", busy, 0);
      chk("amo6_flush", flush, 0);

      cyc(); ent(0, 3'd0); ent(1, 3'd0); ent(2, 3'd0); ex[1] = 1'b1; #1;
      chk("ex1_ack", ack, 4'b0001);
      chk("ex1_exc", exc, 0);
      cyc(); ent(0, 3'd0); ex[0] = 1'b1; #1;
      chk("ex0_exc", exc, 1);
      chk("ex0_ack", ack, 0);
      cyc(); ent(0, 3'd0); ex[0] = 1'b1; halt = 1'b1; #1;
      chk("ex0_halt_exc", exc, 0);

      cyc(); ent(0, 3'd2); ent(1, 3'd0); #1;
      chk("csr_ack", ack, 4'b0001);
      chk("csr_commit", csr_c, 1);
      chk("csr_wdata", wdata[XL-1:0], 64'hC5C5);
      cyc(); ent(0, 3'd2); ent(1, 3'd0); csr_ex = 1'b1; #1;
      chk("csrex_ack", ack, 0);
      chk("csrex_exc", exc, 1);
      chk("csrex_commit", csr_c, 0);

      cyc(); alu4(); step = 1'b1; #1;
      chk("step_ack", ack, 4'b0001);
      cyc(); alu4(); halt = 1'b1; #1;
      chk("halt_ack", ack, 0);
      chk("halt_cnt", rcnt, 0);

      cyc(); ent(0, 3'd3); no_st = 1'b0; #1;
      chk("instret_13", instret, 13);
      chk("rd_busy0", busy, 0);
      cyc(); ent(0, 3'd3); rst = 1'b1; #1;
      chk("rd_pulse", fence, 0);
      chk("rd_ack", ack, 0);
      cyc(); #1;
      chk("rd_busy", busy, 0);
      chk("rd_instret", instret, 0);
      chk("rd_fence", fence, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
